// File: rtl/receiver_pkg.sv
// Shared definitions for the oversampling serial receiver: FSM states,
// parity mode encodings and the 2-of-3 majority helper.
package receiver_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rx_sync_vote.sv
// Two-flop synchroniser for the serial line plus a 2-of-3 majority voter over
// the last three tick-sampled values of the synchronised line.
module rx_sync_vote
   import receiver_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   input  logic tick,
   output logic rx_s,
   output logic vote
);

   logic [1:0] sync_q, sync_d;
   logic [1:0] hist_q, hist_d;

   // NOTE: every variable gets a default at the top of always_comb so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      sync_d = {sync_q[0], rx};
      hist_d = hist_q;
      if (tick) begin
         hist_d = {hist_q[0], sync_q[1]};
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples the
   // pre-edge value of its neighbours, exactly as the hardware does.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         hist_q <= 2'b11;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign rx_s = sync_q[1];
   // hist_q holds the two previous ticks; the live value is the third vote
   assign vote = maj3(hist_q[1], hist_q[0], sync_q[1]);

endmodule

// File: rtl/receiver_cfg.sv
// Configurable oversampling serial receiver: start validation, majority-voted
// data/parity/stop bits, break detection and a held output word with flags.
module receiver_cfg
   import receiver_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 EnClk,
   input  logic                 rx,
   input  logic                 ready_clr,
   output logic [DATA_BITS-1:0] rdout,
   output logic                 ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = 4;
   localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

   logic rx_s;
   logic vote;

   rx_sync_vote u_sync_vote (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .tick  (EnClk),
      .rx_s  (rx_s),
      .vote  (vote)
   );

   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic                   perr_c_q, perr_c_d;
   logic                   ferr_c_q, ferr_c_d;
   logic [DATA_BITS-1:0]   rdout_q, rdout_d;
   logic                   ready_q, ready_d;
   logic                   parity_err_q, parity_err_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic                   bit_done;
   logic                   complete;
   logic                   frm_now;
   logic                   par_x;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      shreg_d      = shreg_q;
      perr_c_d     = perr_c_q;
      ferr_c_d     = ferr_c_q;
      rdout_d      = rdout_q;
      ready_d      = ready_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      overrun_d    = overrun_q;
      complete     = 1'b0;
      frm_now      = ferr_c_q | ~vote;
      par_x        = (^shreg_q) ^ vote;
      bit_done     = (cnt_q == CNT_LAST);

      if (ready_clr) begin
         ready_d      = 1'b0;
         parity_err_d = 1'b0;
         frame_err_d  = 1'b0;
         overrun_d    = 1'b0;
      end

      if (EnClk) begin
         if (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP) begin
            cnt_d = bit_done ? '0 : cnt_q + 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  state_d = S_START;
                  cnt_d   = '0;
               end
            end
            S_START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_d = '0;
                  if (rx_s) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d  = S_DATA;
                     idx_d    = '0;
                     perr_c_d = 1'b0;
                     ferr_c_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                  if (idx_q == DATA_LAST) begin
                     idx_d   = '0;
                     state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (bit_done) begin
                  perr_c_d = (PARITY == PAR_ODD) ? ~par_x : par_x;
                  state_d  = S_STOP;
               end
            end
            S_STOP: begin
               if (bit_done) begin
                  if (idx_q == STOP_LAST) begin
                     complete = 1'b1;
                     idx_d    = '0;
                     state_d  = (frm_now && shreg_q == '0) ? S_BREAK : S_IDLE;
                  end else begin
                     ferr_c_d = frm_now;
                     idx_d    = idx_q + 1'b1;
                  end
               end
            end
            S_BREAK: begin
               if (rx_s) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // a completing word overrides a simultaneous clear
      if (complete) begin
         rdout_d      = shreg_q;
         ready_d      = 1'b1;
         parity_err_d = perr_c_q;
         frame_err_d  = frm_now;
         overrun_d    = overrun_d | (ready_q & ~ready_clr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shreg_q      <= '0;
         perr_c_q     <= 1'b0;
         ferr_c_q     <= 1'b0;
         rdout_q      <= '0;
         ready_q      <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shreg_q      <= shreg_d;
         perr_c_q     <= perr_c_d;
         ferr_c_q     <= ferr_c_d;
         rdout_q      <= rdout_d;
         ready_q      <= ready_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rdout      = rdout_q;
   assign ready      = ready_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_receiver_cfg.sv
// Scoreboard bench for receiver_cfg: an 8N1 and an 8E1 instance driven with
// directed and random frames, checked against a frame-level reference model.
module tb_receiver_cfg;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       ovr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en_clk = 1'b0;
   logic       en_seen = 1'b0;
   logic       rx0 = 1'b1, rx1 = 1'b1;
   logic       clr0 = 1'b0, clr1 = 1'b0;
   logic [7:0] rd0, rd1;
   logic       rdy0, rdy1, pe0, pe1, fe0, fe1, ov0, ov1, busy0, busy1;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t q0[$];
   exp_t q1[$];
   bit   m_ready[2];
   bit   m_ovr[2];

   receiver_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_n1 (
      .clk(clk), .rst_n(rst_n), .EnClk(en_clk), .rx(rx0), .ready_clr(clr0),
      .rdout(rd0), .ready(rdy0), .parity_err(pe0), .frame_err(fe0),
      .overrun(ov0), .busy(busy0)
   );

   receiver_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u_e1 (
      .clk(clk), .rst_n(rst_n), .EnClk(en_clk), .rx(rx1), .ready_clr(clr1),
      .rdout(rd1), .ready(rdy1), .parity_err(pe1), .frame_err(fe1),
      .overrun(ov1), .busy(busy1)
   );

   always #5 clk = ~clk;

   // one-clk-wide tick every second clk, changed away from the active edge
   initial forever begin
      @(negedge clk);
      en_clk = ~en_clk;
   end

   initial forever begin
      @(posedge clk);
      en_seen = en_clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [12:0] out_vec(input int w);
      return (w == 0) ? {rd0, rdy0, pe0, fe0, ov0, busy0} : {rd1, rdy1, pe1, fe1, ov1, busy1};
   endfunction

   function automatic logic [3:0] flags(input int w);
      return (w == 0) ? {rdy0, pe0, fe0, ov0} : {rdy1, pe1, fe1, ov1};
   endfunction

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (!en_clk) @(posedge clk);
      end
      #1;
   endtask

   task automatic set_rx(input int w, input logic v);
      if (w == 0) rx0 = v;
      else        rx1 = v;
   endtask

   // Instance 1 is the even-parity receiver, so only its frames carry pbit.
   task automatic send_frame(input int w, input logic [7:0] d, input logic pbit,
                             input logic stop, input bit hold_low);
      set_rx(w, 1'b0);
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         set_rx(w, d[i]);
         wait_ticks(16);
      end
      if (w == 1) begin
         set_rx(w, pbit);
         wait_ticks(16);
      end
      set_rx(w, stop);
      wait_ticks(16);
      if (!hold_low) set_rx(w, 1'b1);
   endtask

   task automatic push_exp(input int w, input logic [7:0] d, input logic pbit,
                           input logic stop, input bit clr_held);
      exp_t e;
      e.data = d;
      e.perr = (w == 1) && ($countones({d, pbit}) % 2 != 0);
      e.ferr = !stop;
      e.ovr  = clr_held ? 1'b0 : (m_ready[w] | m_ovr[w]);
      m_ready[w] = !clr_held;
      m_ovr[w]   = e.ovr;
      if (w == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic drain(input int w);
      int n;
      n = 0;
      while (((w == 0) ? q0.size() : q1.size()) != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check((w == 0) ? "drain_n1" : "drain_e1", (w == 0) ? q0.size() : q1.size(), 0);
   endtask

   task automatic pulse_clr(input int w);
      if (w == 0) clr0 = 1'b1;
      else        clr1 = 1'b1;
      @(posedge clk);
      #1;
      clr0 = 1'b0;
      clr1 = 1'b0;
      m_ready[w] = 1'b0;
      m_ovr[w]   = 1'b0;
      check((w == 0) ? "clr_flags_n1" : "clr_flags_e1", flags(w), 0);
   endtask

   // Monitor: a word is presented when ready rises or the held word/flags change.
   initial begin : monitor
      logic [10:0] cur;
      logic        rdy;
      logic [10:0] prev_cur[2];
      logic        prev_rdy[2];
      exp_t        e;
      prev_cur[0] = '0; prev_cur[1] = '0;
      prev_rdy[0] = 1'b0; prev_rdy[1] = 1'b0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            cur = (i == 0) ? {rd0, pe0, fe0, ov0} : {rd1, pe1, fe1, ov1};
            rdy = (i == 0) ? rdy0 : rdy1;
            if (!rst_n) begin
               rdy = 1'b0;
            end else if (rdy && (!prev_rdy[i] || cur != prev_cur[i])) begin
               if (!prev_rdy[i]) check("ready_on_tick_edge", en_seen, 1);
               if (i == 0 && q0.size() > 0) begin
                  e = q0.pop_front();
                  check("word_n1", cur, e);
               end else if (i == 1 && q1.size() > 0) begin
                  e = q1.pop_front();
                  check("word_e1", cur, e);
               end else begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL spurious_word dut%0d: got 0x%0h, expected no word", i, cur);
               end
            end
            prev_cur[i] = cur;
            prev_rdy[i] = rdy;
         end
      end
   end

   initial begin : stimulus
      logic [7:0] d;
      logic       pb, sb;
      int         w;

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_n1", out_vec(0), 0);
      check("reset_e1", out_vec(1), 0);
      @(negedge clk) rst_n = 1'b1;
      wait_ticks(4);

      // clean 8N1 word
      push_exp(0, 8'hA5, 1'b0, 1'b1, 1'b0);
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0);
      wait_ticks(20);
      drain(0);
      pulse_clr(0);

      // even parity with a wrong parity bit
      push_exp(1, 8'h03, 1'b1, 1'b1, 1'b0);
      send_frame(1, 8'h03, 1'b1, 1'b1, 1'b0);
      wait_ticks(20);
      drain(1);
      pulse_clr(1);

      // stop bit low
      push_exp(0, 8'h5A, 1'b0, 1'b0, 1'b0);
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
      wait_ticks(20);
      drain(0);
      pulse_clr(0);

      // break: all-zero frame, line held low long enough for a full frame
      push_exp(0, 8'h00, 1'b0, 1'b0, 1'b0);
      send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
      drain(0);
      pulse_clr(0);
      wait_ticks(200);
      check("break_hold_ready_busy", {rdy0, busy0}, 2'b01);
      set_rx(0, 1'b1);
      wait_ticks(4);
      check("break_exit_busy", busy0, 0);
      wait_ticks(20);

      // overrun then clear
      push_exp(0, 8'h11, 1'b0, 1'b1, 1'b0);
      send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0);
      wait_ticks(20);
      drain(0);
      push_exp(0, 8'h22, 1'b0, 1'b1, 1'b0);
      send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0);
      wait_ticks(20);
      drain(0);
      pulse_clr(0);

      // false start: 4 ticks low
      set_rx(0, 1'b0);
      wait_ticks(4);
      check("false_start_busy", busy0, 1);
      set_rx(0, 1'b1);
      wait_ticks(20);
      check("false_start_idle", {rdy0, busy0}, 2'b00);

      // completion while ready_clr is held high: completion wins, no overrun
      push_exp(0, 8'h77, 1'b0, 1'b1, 1'b0);
      send_frame(0, 8'h77, 1'b0, 1'b1, 1'b0);
      wait_ticks(20);
      drain(0);
      clr0 = 1'b1;
      m_ready[0] = 1'b0;
      m_ovr[0]   = 1'b0;
      push_exp(0, 8'h88, 1'b0, 1'b1, 1'b1);
      send_frame(0, 8'h88, 1'b0, 1'b1, 1'b0);
      wait_ticks(20);
      drain(0);
      clr0 = 1'b0;
      check("clr_held_ready", rdy0, 0);

      // reset during data bit 3 with an unread word pending
      push_exp(0, 8'h6B, 1'b0, 1'b1, 1'b0);
      send_frame(0, 8'h6B, 1'b0, 1'b1, 1'b0);
      wait_ticks(20);
      drain(0);
      d = 8'hC3;
      set_rx(0, 1'b0);
      wait_ticks(16);
      for (int i = 0; i < 3; i++) begin
         set_rx(0, d[i]);
         wait_ticks(16);
      end
      set_rx(0, d[3]);
      wait_ticks(8);
      #2 rst_n = 1'b0;
      #1;
      check("midframe_reset_n1", out_vec(0), 0);
      rx0 = 1'b1;
      m_ready[0] = 1'b0; m_ovr[0] = 1'b0;
      m_ready[1] = 1'b0; m_ovr[1] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_ticks(4);
      push_exp(0, 8'h3C, 1'b0, 1'b1, 1'b0);
      send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0);
      wait_ticks(20);
      drain(0);
      pulse_clr(0);

      // random frames on both instances, sometimes left unread to provoke overrun
      for (int k = 0; k < 16; k++) begin
         w  = k % 2;
         d  = 8'($urandom);
         pb = 1'($urandom);
         sb = ($urandom_range(0, 3) != 0);
         push_exp(w, d, pb, sb, 1'b0);
         send_frame(w, d, pb, sb, 1'b0);
         wait_ticks(20);
         drain(w);
         if (m_ovr[w] || $urandom_range(0, 2) != 0) pulse_clr(w);
      end
      pulse_clr(0);
      pulse_clr(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/receiver_cfg.md
RECEIVER_CFG -- requirements
Module: receiver_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning EnClk ticks per bit (legal 8 or 16).
REQ-003 SHALL have parameter PARITY, default 0, meaning parity mode (0 none, 1 odd, 2 even).
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame (legal 1 or 2).
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port EnClk, input, 1, meaning oversample tick, one clk cycle wide.
REQ-008 SHALL have port rx, input, 1, meaning asynchronous serial line, idle high.
REQ-009 SHALL have port ready_clr, input, 1, meaning consumer acknowledge.
REQ-010 SHALL have port rdout, output, DATA_BITS, meaning last received word.
REQ-011 SHALL have port ready, output, 1, meaning unread word held in rdout.
REQ-012 SHALL have port parity_err, output, 1, meaning parity mismatch on the held word.
REQ-013 SHALL have port frame_err, output, 1, meaning a stop bit sampled low on the held word.
REQ-014 SHALL have port overrun, output, 1, meaning a word completed while ready was 1.
REQ-015 SHALL have port busy, output, 1, meaning FSM not in IDLE.

Function
REQ-016 rx SHALL pass through a 2-flop synchroniser (reset value 1); all decisions use the synchronised value.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK; state and tick counter SHALL advance only on clk edges where EnClk=1.
REQ-018 IDLE: synchronised rx=0 on a tick -> START, counter=0.
REQ-019 START: counter increments per tick; at counter=OVERSAMPLE/2-1, rx=1 -> IDLE (false start, nothing reported); rx=0 -> DATA, counter=0, bit index=0.
REQ-020 Each data/parity/stop bit SHALL span OVERSAMPLE ticks, counter 0..OVERSAMPLE-1, wrapping to 0.
REQ-021 Bit value SHALL be the 2-of-3 majority of synchronised rx sampled at counter OVERSAMPLE-3, OVERSAMPLE-2, OVERSAMPLE-1, resolved at counter OVERSAMPLE-1.
REQ-022 Data SHALL be LSB first; after DATA_BITS bits -> PARITY if PARITY!=0, else STOP.
REQ-023 PARITY: parity_err candidate = 1 when XOR(data, parity bit) is 0 for odd mode or 1 for even mode.
REQ-024 STOP: each of STOP_BITS bits resolved as in REQ-021; any 0 sets the frame_err candidate.
REQ-025 On resolution of the last stop bit: rdout<=data, ready<=1, parity_err/frame_err<=candidates, next state IDLE, or BREAK if data is all-zero and frame_err is set.
REQ-026 BREAK: stay until synchronised rx=1 on a tick, then IDLE.
REQ-027 Word completion while ready=1 SHALL set overrun and overwrite rdout and the error flags.
REQ-028 ready_clr=1 SHALL clear ready, parity_err, frame_err and overrun on the next clk edge, independent of EnClk.
REQ-029 Completion and ready_clr in the same cycle: completion wins (ready=1, new flags); overrun is not set by that completion.
REQ-030 ready SHALL rise one clk after the EnClk tick resolving the last stop bit.
REQ-031 busy SHALL be 1 in every state except IDLE.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, counter and bit index to 0, synchroniser to 1, rdout to 0, and ready, parity_err, frame_err, overrun, busy to 0.
REQ-033 Reset mid-frame SHALL discard the partial word; the first start after release is detected per REQ-018.

Structure
REQ-034 Package receiver_pkg SHALL hold the FSM state enum and the PARITY mode constants (PAR_NONE, PAR_ODD, PAR_EVEN).
REQ-035 Sub-module rx_sync_vote SHALL contain the synchroniser and 3-sample majority voter.

Verification
REQ-036 8N1, OVERSAMPLE=16, frame 0xA5 -> rdout=0xA5, ready=1, all error flags 0.
REQ-037 8E1, frame 0x03 with parity bit 1 -> rdout=0x03, parity_err=1.
REQ-038 8N1, 0x5A with stop bit 0 -> frame_err=1; all-zero frame with rx held low -> BREAK, no new start until rx=1.
REQ-039 Two frames 0x11 then 0x22, no ready_clr -> rdout=0x22, overrun=1; then ready_clr -> all flags 0.
REQ-040 rx low for 4 ticks then high -> ready stays 0, busy returns to 0.
REQ-041 rst_n low during DATA bit 3 -> all outputs 0 immediately; next 0x3C frame received correctly.
